// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, bit period used by benches, and 8N1 framing.
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define UART_8N1_FRAME_BITS 10

package uart_pkg;
  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_FRAME_BITS   = `UART_8N1_FRAME_BITS;
endpackage

`endif

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the 8N1 UART transmitter; pops on the rising edge of the transmitter's done level.
// Optional macro UART_TX_FIFO_LEVEL_EN adds a 'level' output exposing the current fill count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   tx_ready,
  output logic [UART_DATA_W-1:0] tx_data,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [DEPTH_LOG2:0]    level,
`endif
  input  logic                   tx_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic                   tx_done_q;
  logic                   pop;
  logic                   push;

  assign full     = (count == COUNT_FULL);
  assign empty    = (count == '0);
  // An edge arriving while empty is spurious and must not disturb the pointers.
  assign pop      = tx_done & ~tx_done_q & ~empty;
  assign push     = wr_en & (~full | pop);
  assign tx_ready = ~empty;
  assign tx_data  = empty ? '0 : mem[rd_ptr];

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      tx_done_q <= 1'b0;
      overflow  <= 1'b0;
    end else if (!en) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      tx_done_q <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + COUNT_ONE;
      else if (pop && !push) count <= count - COUNT_ONE;
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: reads are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (en && push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo, including a behavioural 8N1 transmitter for the frame test.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CLKS = UART_CLKS_PER_BIT;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       tb_done;
  logic       model_on;
  logic       model_done;
  logic       uart_txd;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int total = 0;
  int bad   = 0;
  int frames_sent = 0;

  always #5 clk = ~clk;

  assign tx_done = model_on ? model_done : tb_done;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
`ifdef UART_TX_FIFO_LEVEL_EN
    .level    (level),
`endif
    .tx_done  (tx_done)
  );

  // Behavioural transmitter: frame position 0 = start, 1..8 = data, 9 = stop; done high from last data bit.
  int         m_pos;
  int         m_cyc;
  logic [7:0] m_sh;
  logic       m_busy;
  always @(posedge clk) begin
    if (!model_on) begin
      m_busy     <= 1'b0;
      model_done <= 1'b0;
      uart_txd   <= 1'b1;
      m_pos      <= 0;
      m_cyc      <= 0;
    end else if (!m_busy) begin
      uart_txd <= 1'b1;
      if (tx_ready && !model_done) begin
        m_busy      <= 1'b1;
        m_sh        <= tx_data;
        m_pos       <= 0;
        m_cyc       <= 0;
        uart_txd    <= 1'b0;
        frames_sent <= frames_sent + 1;
      end
    end else if (m_cyc == CLKS - 1) begin
      m_cyc <= 0;
      if (m_pos == 9) begin
        m_busy     <= 1'b0;
        model_done <= 1'b0;
        uart_txd   <= 1'b1;
      end else begin
        m_pos    <= m_pos + 1;
        uart_txd <= (m_pos < 8) ? m_sh[m_pos] : 1'b1;
        if (m_pos == 7) model_done <= 1'b1;
      end
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", tx_ready); end
    @(negedge clk); rstn = 1'b1; @(negedge clk);
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    total++; if (tx_data !== 8'h30) begin bad++; $display("[TB] FAIL queued_head got=%h want=30", tx_data); end
    #2 rstn = 1'b0;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL midop_empty got=%b want=1", empty); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL midop_ready got=%b want=0", tx_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL midop_ovf got=%b want=0", overflow); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL midop_data got=%h want=00", tx_data); end
    @(negedge clk); rstn = 1'b1; @(negedge clk);
  endtask

  task automatic test_single();
    push_byte(8'h41);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready got=%b want=1", tx_ready); end
    total++; if (tx_data !== 8'h41) begin bad++; $display("[TB] FAIL single_data got=%h want=41", tx_data); end
`ifdef UART_TX_FIFO_LEVEL_EN
    total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL single_level got=%0d want=1", level); end
`endif
    tb_done = 1'b1;
    @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL single_pop got=%b want=1", empty); end
    repeat (10) @(negedge clk);
    push_byte(8'h42);
    repeat (889) @(negedge clk);
    total++; if (tx_data !== 8'h42) begin bad++; $display("[TB] FAIL held_done_data got=%h want=42", tx_data); end
    tb_done = 1'b0;
    @(negedge clk);
    pulse_done();
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL held_then_pop got=%b want=1", empty); end
  endtask

  task automatic test_fill_overflow();
    int errs = 0;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
    end
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full got=%b want=1", full); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL fill_ovf got=%b want=1", overflow); end
`ifdef UART_TX_FIFO_LEVEL_EN
    total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL fill_level got=%0d want=16", level); end
`endif
    for (int i = 1; i <= 16; i++) begin
      if (tx_data !== 8'(i)) begin
        errs++;
        $display("[TB] FAIL drain_order idx=%0d got=%h want=%h", i, tx_data, 8'(i));
      end
      pulse_done();
    end
    total++; if (errs != 0) bad++;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty got=%b want=1", empty); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b want=1", overflow); end
    push_byte(8'h5A);
    total++; if (tx_data !== 8'h5A) begin bad++; $display("[TB] FAIL wrap_data got=%h want=5a", tx_data); end
    pulse_done();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
    en = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    en = 1'b1; wr_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL flush_empty got=%b want=1", empty); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL flush_ovf got=%b want=0", overflow); end
    @(negedge clk);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_drop got=%b want=0", tx_ready); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL flush_data got=%h want=00", tx_data); end
  endtask

  task automatic test_full_push_pop();
    int errs = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL pp_prefull got=%b want=1", full); end
    wr_en = 1'b1; wr_data = 8'hAA; tb_done = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; tb_done = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL pp_full got=%b want=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL pp_ovf got=%b want=0", overflow); end
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] want;
      want = (i == 16) ? 8'hAA : 8'h20 + 8'(i);
      if (tx_data !== want) begin
        errs++;
        $display("[TB] FAIL pp_order idx=%0d got=%h want=%h", i, tx_data, want);
      end
      pulse_done();
    end
    total++; if (errs != 0) bad++;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL pp_empty got=%b want=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    logic [9:0] got;
    logic [9:0] want;
    int w;
    bytes[0] = 8'h55; bytes[1] = 8'hC3;
    model_on = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_data = 8'hC3;
    @(negedge clk);
    wr_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      w = 0;
      while (uart_txd !== 1'b0 && w < 5000) begin @(negedge clk); w++; end
      total++; if (w >= 5000) begin bad++; $display("[TB] FAIL frame_start f=%0d got=timeout want=start", f); end
      if (f == 1) begin
        total++; if (w > CLKS / 2 + 4) begin bad++; $display("[TB] FAIL frame_gap got=%0d want<=%0d", w, CLKS / 2 + 4); end
      end
      repeat (CLKS / 2) @(negedge clk);
      for (int b = 0; b < 10; b++) begin
        got[b] = uart_txd;
        if (b < 9) repeat (CLKS) @(negedge clk);
      end
      want = {1'b1, bytes[f], 1'b0};
      total++; if (got !== want) begin bad++; $display("[TB] FAIL frame_bits f=%0d got=%b want=%b", f, got, want); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL frames_empty got=%b want=1", empty); end
    repeat (2000) @(negedge clk);
    total++; if (frames_sent != 2) begin bad++; $display("[TB] FAIL frame_count got=%0d want=2", frames_sent); end
    total++; if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL line_idle got=%b want=1", uart_txd); end
    model_on = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    tb_done = 1'b0; model_on = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_overflow();
    test_flush();
    test_full_push_pop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
